ascon_serial_loader: RTL

- Upstream feeder for the serial-interface Ascon encryption core.
- Accepts one parallel job (key, nonce, associated data, plaintext) through a valid/ready handshake.
- Splits each operand into three Boolean shares and drives the core's 3-bit serial share inputs MSB-first, one bit per clock.
- Generates the core's per-cycle fault/masking randomness, sequences the core's reset, start and output-drain window, and signals job completion.

---
 rtl/ascon_loader_pkg.sv | 63 ++++++
 rtl/ascon_xorshift64.sv | 28 ++
 rtl/ascon_serial_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ascon_loader_pkg.sv
// Shared types, sizing helpers and PRNG step for the Ascon serial loader.
// Optional ASCON_LOADER_ZERO_MASK_EN is consumed by ascon_serial_loader.
package ascon_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_START,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int unsigned NONCE_W = 128;

  localparam int unsigned PB_KEY   = 0;
  localparam int unsigned PB_NONCE = 2;
  localparam int unsigned PB_AD    = 4;
  localparam int unsigned PB_PT    = 6;
  localparam int unsigned PB_R64   = 8;
  localparam int unsigned PB_R128  = 15;
  localparam int unsigned PB_RPT   = 16;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned calc_n(
    input int unsigned k,
    input int unsigned l,
    input int unsigned y
  );
    return max2(max2(k, NONCE_W), max2(l, y));
  endfunction

  function automatic int unsigned calc_d(
    input int unsigned y
  );
    return max2(y, 128) + 1;
  endfunction

  function automatic logic [63:0] xs64_step(
    input logic [63:0] x
  );
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // {s2, s1, s0} with s1 = m[0], s2 = m[1]
  function automatic logic [2:0] share3(
    input logic       d,
    input logic [1:0] m
  );
    return {m[1], m[0], d ^ m[0] ^ m[1]};
  endfunction

endpackage

// File: rtl/ascon_xorshift64.sv
// Free-running xorshift64 generator; reloads SEED on synchronous reset.
module ascon_xorshift64
  import ascon_loader_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [63:0] state_o
);

  logic [63:0] x_q;
  logic [63:0] x_d;

  always_comb begin
    x_d = x_q;
    if (step_i) x_d = xs64_step(x_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) x_q <= SEED;
    else       x_q <= x_d;
  end

  assign state_o = x_q;

endmodule

// File: rtl/ascon_serial_loader.sv
// Job loader: masks operands into 3 shares and sequences the serial core.
// Define ASCON_LOADER_ZERO_MASK_EN to force all masks/randomness to zero.
module ascon_serial_loader
  import ascon_loader_pkg::*;
#(
  parameter int unsigned K    = 128,
  parameter int unsigned L    = 80,
  parameter int unsigned Y    = 80,
  parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [L-1:0] ad_i,
  input  logic [Y-1:0] pt_i,
  output logic         core_rst,
  output logic [2:0]   keyxSI,
  output logic [2:0]   noncexSI,
  output logic [2:0]   associated_dataxSI,
  output logic [2:0]   plain_textxSI,
  output logic [6:0]   r_64xSI,
  output logic         r_128xSI,
  output logic         r_ptxSI,
  output logic         encryption_startxSI,
  input  logic         encryption_readyxSO,
  output logic         done
);

  localparam int unsigned N    = calc_n(K, L, Y);
  localparam int unsigned D    = calc_d(Y);
  localparam int unsigned CMAX = max2(N, D);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);

`ifdef ASCON_LOADER_ZERO_MASK_EN
  localparam logic [63:0] RMASK = 64'h0;
`else
  localparam logic [63:0] RMASK = {64{1'b1}};
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_rst_q, core_rst_d;
  logic [K-1:0]  key_q, key_d;
  logic [127:0]  nonce_q, nonce_d;
  logic [L-1:0]  ad_q, ad_d;
  logic [Y-1:0]  pt_q, pt_d;

  logic [63:0]   prng;
  logic [63:0]   rnd;

  ascon_xorshift64 #(
    .SEED(SEED)
  ) u_prng (
    .clk_i  (clk),
    .rst_i  (rst),
    .step_i (1'b1),
    .state_o(prng)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      key_q      <= '0;
      nonce_q    <= '0;
      ad_q       <= '0;
      pt_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ad_q       <= ad_d;
      pt_q       <= pt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    core_rst_d = core_rst_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ad_d       = ad_q;
    pt_d       = pt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d      = key_i;
          nonce_d    = nonce_i;
          ad_d       = ad_i;
          pt_d       = pt_i;
          cnt_d      = '0;
          core_rst_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        key_d   = key_q << 1;
        nonce_d = nonce_q << 1;
        ad_d    = ad_q << 1;
        pt_d    = pt_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_START;
      S_START: begin
        if (encryption_readyxSO) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == D_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        core_rst_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready            = (state_q == S_IDLE);
  assign done                = (state_q == S_DONE);
  assign encryption_startxSI = (state_q == S_START);
  assign core_rst            = core_rst_q;

  assign rnd = prng & RMASK;

  // Each stream is live only for its own length; beyond it, all shares are 0
  logic sh_act, k_act, n_act, a_act, p_act, r64_act, r128_act;

  assign sh_act   = (state_q == S_SHIFT);
  assign k_act    = sh_act && (cnt_q < CW'(K));
  assign n_act    = sh_act && (cnt_q < CW'(NONCE_W));
  assign a_act    = sh_act && (cnt_q < CW'(L));
  assign p_act    = sh_act && (cnt_q < CW'(Y));
  assign r64_act  = sh_act && (cnt_q < CW'(64));
  assign r128_act = sh_act && (cnt_q < CW'(128));

  assign keyxSI = k_act ?
    share3(key_q[K-1], rnd[PB_KEY +: 2]) : 3'b000;
  assign noncexSI = n_act ?
    share3(nonce_q[127], rnd[PB_NONCE +: 2]) : 3'b000;
  assign associated_dataxSI = a_act ?
    share3(ad_q[L-1], rnd[PB_AD +: 2]) : 3'b000;
  assign plain_textxSI = p_act ?
    share3(pt_q[Y-1], rnd[PB_PT +: 2]) : 3'b000;

  assign r_64xSI  = r64_act  ? rnd[PB_R64 +: 7] : 7'h00;
  assign r_128xSI = r128_act ? rnd[PB_R128]     : 1'b0;
  assign r_ptxSI  = p_act    ? rnd[PB_RPT]      : 1'b0;

  logic unused_prng;
  assign unused_prng = ^rnd[63:17];

endmodule
